// File: rtl/seq_det_pkg.sv
// Shared types, defaults and width helpers for the configurable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam logic        DEF_OVERLAP = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold a pattern length in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill tracking and length-masked compare; hit_c_o flags a match on the accepting edge.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               hit_c_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift_c, mask_c;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc_c;
  logic               hit_c;

  // Hit is judged on the post-shift window so the match pulse can be registered on the same edge.
  always_comb begin
    hist_shift_c = {hist_q[MAX_LEN-2:0], bit_i};
    fill_inc_c   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask_c[i] = (i < int'(len_i));
    end
    hit_c  = shift_i && (((hist_shift_c ^ pattern_i) & mask_c) == '0) && (fill_inc_c >= len_i);
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = hist_shift_c;
      fill_d = (hit_c && !overlap_i) ? '0 : fill_inc_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hit_c_o = hit_c;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Runtime-configurable serial pattern detector: config registers, run FSM, match counter and bit handshake.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned  MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned  CNT_W   = DEF_CNT_W,
  localparam int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               cfg_err_q, cfg_err_d;
  logic               match_q, bit_ready_q, busy_q, done_q;
  logic               accept_c, hit_c, clr_c, len_ok_c;

  assign accept_c = bit_valid & bit_ready_q;
  assign len_ok_c = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_c),
    .shift_i   (accept_c),
    .bit_i     (bit_in),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .hit_c_o   (hit_c)
  );

  // Next state, config update and match counting; a config write lands before a same-cycle start.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    thresh_d    = thresh_q;
    match_cnt_d = match_cnt_q;
    cfg_err_d   = 1'b0;
    clr_c       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (cfg_we) begin
          if (len_ok_c) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            thresh_d  = cfg_thresh;
          end else begin
            cfg_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        if (start) begin
          state_d     = RUN;
          clr_c       = 1'b1;
          match_cnt_d = '0;
        end
      end
      RUN: begin
        if (hit_c) begin
          match_cnt_d = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
        end
        if (abort) begin
          state_d = IDLE;
        end else if (hit_c && (thresh_q != '0) && (match_cnt_q + CNT_W'(1) == thresh_q)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= LEN_W'(MAX_LEN);
      overlap_q   <= DEF_OVERLAP;
      thresh_q    <= '0;
      match_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
      match_q     <= 1'b0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      thresh_q    <= thresh_d;
      match_cnt_q <= match_cnt_d;
      cfg_err_q   <= cfg_err_d;
      match_q     <= hit_c;
      bit_ready_q <= (state_d == RUN);
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  assign cfg_err   = cfg_err_q;
  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign bit_ready = bit_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl against a bit-list reference model of the detector rules.
module tb_seq_detect_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clk, rst_n;
  logic               cfg_we, cfg_overlap, cfg_err;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_thresh, match_cnt;
  logic               start, abort, bit_valid, bit_in, bit_ready, match, busy, done;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .start(start),
    .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {cfg_err, bit_ready, match, busy, done, match_cnt};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: run state (0 idle, 1 run, 2 done), config, accepted-bit list and match bookkeeping.
  int          ms;
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ov;
  int          m_th;
  int          m_cnt;
  int          m_since;
  bit          mq[$];
  logic [12:0] exp_v;

  task automatic model_reset();
    ms = 0; m_pat = 8'h00; m_len = 8; m_ov = 1'b0; m_th = 0; m_cnt = 0; m_since = 0;
    mq.delete();
  endtask

  // Drive one cycle of inputs, advance the model, and sample the DUT 1 time unit after the edge.
  task automatic step(input bit we, input logic [7:0] pat, input logic [3:0] len, input bit ov,
                      input logic [7:0] th, input bit st, input bit ab, input bit v, input bit b);
    bit err, hit;
    cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_thresh = th;
    start = st; abort = ab; bit_valid = v; bit_in = b;
    err = 1'b0; hit = 1'b0;
    if (ms != 1) begin
      if (we) begin
        if (len >= 1 && len <= 8) begin
          m_pat = pat; m_len = int'(len); m_ov = ov; m_th = int'(th);
        end else err = 1'b1;
        ms = 0;
      end
      if (st) begin
        ms = 1; m_cnt = 0; m_since = 0; mq.delete();
      end
    end else begin
      if (v) begin
        mq.push_back(b);
        m_since++;
        if (m_since >= m_len) begin
          hit = 1'b1;
          for (int j = 0; j < m_len; j++)
            if (mq[mq.size() - 1 - j] != m_pat[j]) hit = 1'b0;
        end
        if (hit) begin
          if (m_cnt < 255) m_cnt++;
          if (!m_ov) m_since = 0;
        end
      end
      if (ab) ms = 0;
      else if (hit && m_th != 0 && m_cnt == m_th) ms = 2;
    end
    @(posedge clk);
    #1;
    exp_v = {err, ms == 1, hit, ms == 1, ms == 2, 8'(m_cnt)};
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input bit ov, input logic [7:0] th);
    step(1'b1, pat, len, ov, th, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bitc(input bit v, input bit b);
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, v, b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_thresh = '0;
    start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 13'd0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", obs); end
    rst_n = 1'b1;
    bitc(1'b1, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_nonoverlap();
    logic [10:0] s;
    s = 11'b01010101010;
    cfg(8'b01010, 4'd5, 1'b0, 8'd0);
    go();
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL nonovl_start: got %b want %b", obs, exp_v); end
    for (int i = 10; i >= 0; i--) begin
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL nonovl bit %0d: got %b want %b", 11 - i, obs, exp_v); end
    end
    n_checks++;
    if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL nonovl_cnt: got %0d want 2", match_cnt); end
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL nonovl_abort: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_overlap();
    logic [10:0] s;
    s = 11'b01010101010;
    cfg(8'b01010, 4'd5, 1'b1, 8'd0);
    go();
    for (int i = 10; i >= 0; i--) begin
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL ovl bit %0d: got %b want %b", 11 - i, obs, exp_v); end
    end
    n_checks++;
    if (match_cnt !== 8'd4) begin n_fail++; $display("FAIL ovl_cnt: got %0d want 4", match_cnt); end
  endtask

  task automatic test_threshold();
    logic [9:0] s;
    s = 10'b0101010101;
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'b01010, 4'd5, 1'b1, 8'd2);
    go();
    for (int i = 9; i >= 0; i--) begin
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL thresh bit %0d: got %b want %b", 10 - i, obs, exp_v); end
    end
    n_checks++;
    if ({done, bit_ready, match_cnt} !== {1'b1, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL thresh_done: got done=%b rdy=%b cnt=%0d want 1 0 2", done, bit_ready, match_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [10:0] s;
    s = 11'b01010101010;
    cfg(8'b01010, 4'd5, 1'b1, 8'd0);
    go();
    for (int i = 10; i >= 0; i--) begin
      bitc(1'b0, 1'($urandom));
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL gap idle %0d: got %b want %b", 11 - i, obs, exp_v); end
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL gap bit %0d: got %b want %b", 11 - i, obs, exp_v); end
    end
    n_checks++;
    if (match_cnt !== 8'd4) begin n_fail++; $display("FAIL gap_cnt: got %0d want 4", match_cnt); end
  endtask

  task automatic test_cfg_err();
    logic [4:0] s;
    s = 5'b01010;
    cfg(8'b111, 4'd3, 1'b0, 8'd1);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cfg_in_run: got %b want %b", obs, exp_v); end
    for (int i = 4; i >= 0; i--) begin
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL cfgrun bit %0d: got %b want %b", 5 - i, obs, exp_v); end
    end
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'hFF, 4'd0, 1'b0, 8'd1);
    n_checks++;
    if (obs !== exp_v || cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_len0: got %b want %b", obs, exp_v); end
    bitc(1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cfg_err_pulse: got %b want %b", obs, exp_v); end
    cfg(8'hFF, 4'd9, 1'b0, 8'd1);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cfg_len9: got %b want %b", obs, exp_v); end
    go();
    for (int i = 4; i >= 0; i--) begin
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL cfgkeep bit %0d: got %b want %b", 5 - i, obs, exp_v); end
    end
    n_checks++;
    if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL cfg_unchanged_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_abort_reset();
    logic [4:0] s;
    s = 5'b01010;
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs !== exp_v || busy !== 1'b0) begin n_fail++; $display("FAIL abort_start: got %b want %b", obs, exp_v); end
    go();
    for (int i = 4; i >= 0; i--) begin
      bitc(1'b1, s[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL prereset bit %0d: got %b want %b", 5 - i, obs, exp_v); end
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 13'd0) begin n_fail++; $display("FAIL midrun_reset: got %b want 0", obs); end
    cfg_we = 0; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    go();
    for (int i = 0; i < 9; i++) begin
      bitc(1'b1, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL default_cfg bit %0d: got %b want %b", i + 1, obs, exp_v); end
    end
    n_checks++;
    if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL default_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_saturate();
    step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'h01, 4'd1, 1'b1, 8'd0);
    go();
    for (int i = 0; i < 260; i++) begin
      bitc(1'b1, 1'b1);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL sat bit %0d: got %b want %b", i + 1, obs, exp_v); end
    end
    n_checks++;
    if (match_cnt !== 8'hFF || match !== 1'b1) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", match_cnt); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [3:0] len;
      len = (r % 2 == 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(1, 8));
      if (ms == 1) step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      cfg(8'($urandom), len, 1'($urandom), 8'($urandom_range(0, 3)));
      go();
      for (int c = 0; c < 50; c++) begin
        step(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, ($urandom % 16) == 0, ($urandom % 40) == 0,
             ($urandom % 4) != 0, 1'($urandom));
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rand r%0d c%0d: got %b want %b", r, c, obs, exp_v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_threshold();
    test_gaps();
    test_cfg_err();
    test_abort_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
